feature_extractor: RTL and testbench
====================================

# feature_extractor

Streaming feature-extraction block: accepts one 32×32 8-bit grayscale frame in raster order and applies a fixed 3×3 signed convolution with zero padding. It then applies 2×2 max pooling with stride 2 and emits 256 signed 22-bit features (16×16) in raster order. It sits between the pixel source and the classifier/accumulator stage of the NPU datapath, and signals frame completion with a done pulse.

## Interface
- IMG_W, 32, frame width in pixels
- IMG_H, 32, frame height in pixels
- K00..K22, {-1,0,1,-2,0,2,-1,0,1}, signed 8-bit kernel weights, row-major (K00 top-left, K22 bottom-right)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- start_signal  in  1  one-cycle pulse that arms a new frame
- pixel_valid_in  in  1  pixel_in is valid this cycle
- pixel_in  in  8  unsigned pixel, raster order (row 0 col 0 first)
- final_result_out  out  22 signed  pooled feature
- final_result_valid  out  1  final_result_out is valid this cycle
- final_done_signal  out  1  one-cycle pulse after the last feature of a frame

## Operation
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on start_signal.
  - RUN -> FLUSH after the 1024th accepted pixel.
  - FLUSH -> DONE after the 256th feature is emitted.
  - DONE -> IDLE after one cycle, with final_done_signal=1 during DONE.
- Pixel acceptance:
  - Pixels are accepted only in RUN when pixel_valid_in=1.
  - pixel_valid_in is ignored in IDLE, FLUSH and DONE.
  - Gaps between valid pixels are allowed.
- start_signal in RUN or FLUSH restarts the frame: all counters and buffers clear and the next accepted pixel is (0,0).
- Convolution:
  - conv(r,c) = Σ_{i,j∈0..2} K_ij · p(r+i−1, c+j−1).
  - p is pixel_in zero-extended; out-of-frame pixels are 0.
  - Produces 32×32 results.
  - Implement with two IMG_W-deep line buffers plus a 3×3 window register. Column masking enforces the zero padding at the left and right edges; no wrap between rows.
- FLUSH injects 33 internal zero pixels, one per cycle, to complete windows for row 31. These virtual pixels never consume input.
- Arithmetic:
  - Products are 8-bit unsigned × 8-bit signed; accumulate in 22-bit signed.
  - Max |sum| is 9·255·128 = 293760, so no overflow or saturation logic is needed.
- Pooling:
  - out(m,n) = max over conv(2m..2m+1, 2n..2n+1), signed compare.
  - Even conv rows store pairwise column maxima in a 16-entry buffer. On odd rows, at each odd column, emit the max of the stored value and the current pair.
  - No ReLU.
- Output order is raster: out(0,0) … out(0,15), out(1,0) … out(15,15).

## Timing
- Reset values: final_result_out=0, final_result_valid=0, final_done_signal=0, state=IDLE. Line buffers, counters and the pool buffer are cleared.
- Reset asserted mid-frame aborts the frame immediately; no further valid or done pulse is produced for that frame.
- The conv result for center (r,c) is registered 1 cycle after the cycle in which pixel (r+1,c+1) is accepted, or the equivalent virtual/padded position.
- final_result_valid rises 1 cycle after the conv result for (2m+1,2n+1) is registered. Total latency is 2 cycles from completion of that window.
- final_result_valid is a single-cycle pulse per feature; exactly 256 pulses occur per frame.
- final_done_signal pulses exactly one cycle after the 256th final_result_valid, never coincident with it.
- start_signal coincident with pixel_valid_in:
  - start is registered first.
  - A pixel in the same cycle as start from IDLE is not accepted.
  - The first pixel is taken on the following valid cycle.

## Test plan
- All-zero frame with default kernel -> 256 valid outputs, all 0, then one done pulse.
- Constant frame of 10 -> out(m,0)=40 for all m; every other output is 0; 256 valids; done pulse.
- Single pixel (2,2)=100, rest 0, default kernel:
  - out(0,0)=100, out(1,0)=200, out(0,1)=0, out(1,1)=0.
  - All other outputs are 0.
- Constant-10 frame with random 1–3 cycle gaps in pixel_valid_in -> output values identical to the gap-free run, 256 valids.
- Reset mid-frame:
  - Pull rst low at pixel 500 -> outputs go to 0 with no done pulse.
  - A subsequent start plus a full zero frame yields 256 zeros and a done pulse.
- start_signal re-pulsed after 300 pixels, then a full single-pixel frame -> outputs match the single-pixel scenario exactly.

Source files
------------

// File: rtl/feature_extractor.sv
// rtl/feature_extractor.sv - streaming 3x3 convolution with 2x2 max pooling over one frame
module feature_extractor #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter logic signed [7:0] K00 = -8'sd1,
  parameter logic signed [7:0] K01 = 8'sd0,
  parameter logic signed [7:0] K02 = 8'sd1,
  parameter logic signed [7:0] K10 = -8'sd2,
  parameter logic signed [7:0] K11 = 8'sd0,
  parameter logic signed [7:0] K12 = 8'sd2,
  parameter logic signed [7:0] K20 = -8'sd1,
  parameter logic signed [7:0] K21 = 8'sd0,
  parameter logic signed [7:0] K22 = 8'sd1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_signal,
  input  logic               pixel_valid_in,
  input  logic [7:0]         pixel_in,
  output logic signed [21:0] final_result_out,
  output logic               final_result_valid,
  output logic               final_done_signal
);
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NPOS  = NPIX + IMG_W + 1;   // real pixels plus trailing virtual zeros
  localparam int NFEAT = NPIX / 4;
  localparam int CW    = $clog2(IMG_W);
  localparam int KW    = $clog2(NPOS + 1);
  localparam int FW    = $clog2(NFEAT + 1);
  localparam logic signed [7:0] KM [3][3] = '{'{K00, K01, K02}, '{K10, K11, K12}, '{K20, K21, K22}};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;

  logic [7:0]         lb1_q [IMG_W];
  logic [7:0]         lb2_q [IMG_W];
  logic [7:0]         win_q [3][2];
  logic [KW-1:0]      k_q;
  logic [CW-1:0]      tc_q;
  logic               row_odd_q;
  logic signed [21:0] conv_q, conv_d;
  logic               conv_v_q, conv_row_odd_q;
  logic [CW-1:0]      conv_c_q;
  logic signed [21:0] pair_q;
  logic signed [21:0] pool_q [IMG_W/2];
  logic signed [21:0] out_q;
  logic               valid_q;
  logic [FW-1:0]      feat_cnt_q;

  logic               restart, clr, shift, conv_fire;
  logic [7:0]         px;
  logic [7:0]         new_col [3];
  logic [7:0]         col_l [3], col_m [3], col_r [3];
  logic signed [21:0] pair_max;

  function automatic logic signed [21:0] mac(input logic [7:0] p, input logic signed [7:0] k);
    logic signed [17:0] a, b, pr;
    a  = {10'b0, p};
    b  = {{10{k[7]}}, k};
    pr = a * b;
    return {{4{pr[17]}}, pr};
  endfunction

  function automatic logic signed [21:0] smax(input logic signed [21:0] a, input logic signed [21:0] b);
    return (a > b) ? a : b;
  endfunction

  // State register; reset returns to IDLE
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: start re-arms from IDLE/RUN/FLUSH, DONE lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_signal) state_d = RUN;
      RUN:   if (start_signal) state_d = RUN;
             else if (shift && k_q == KW'(NPIX - 1)) state_d = FLUSH;
      FLUSH: if (start_signal) state_d = RUN;
             else if (valid_q && feat_cnt_q == FW'(NFEAT)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stream advance, window assembly with edge masking, and the 3x3 MAC
  always_comb begin
    restart   = start_signal && (state_q != DONE);
    clr       = !rst || restart;
    shift     = !start_signal && ((state_q == RUN && pixel_valid_in) ||
                                  (state_q == FLUSH && k_q < KW'(NPOS)));
    px        = (state_q == RUN) ? pixel_in : 8'd0;
    conv_fire = shift && (k_q >= KW'(IMG_W + 1));
    new_col[0] = lb2_q[IMG_W-1];
    new_col[1] = lb1_q[IMG_W-1];
    new_col[2] = px;
    conv_d = '0;
    for (int i = 0; i < 3; i++) begin
      col_l[i] = (tc_q == '0) ? 8'd0 : win_q[i][0];
      col_m[i] = win_q[i][1];
      col_r[i] = (tc_q == CW'(IMG_W - 1)) ? 8'd0 : new_col[i];
      conv_d = conv_d + mac(col_l[i], KM[i][0]) + mac(col_m[i], KM[i][1]) + mac(col_r[i], KM[i][2]);
    end
    pair_max = smax(pair_q, conv_q);
  end

  // Line buffers, window and position counters; cleared on reset or frame restart
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb1_q[i] <= '0;
        lb2_q[i] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= '0;
        win_q[i][1] <= '0;
      end
      k_q       <= '0;
      tc_q      <= '0;
      row_odd_q <= 1'b0;
    end else if (shift) begin
      for (int i = IMG_W - 1; i > 0; i--) begin
        lb1_q[i] <= lb1_q[i-1];
        lb2_q[i] <= lb2_q[i-1];
      end
      lb1_q[0] <= px;
      lb2_q[0] <= lb1_q[IMG_W-1];
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= new_col[i];
      end
      k_q <= k_q + 1'b1;
      if (conv_fire) begin
        if (tc_q == CW'(IMG_W - 1)) begin
          tc_q      <= '0;
          row_odd_q <= ~row_odd_q;
        end else begin
          tc_q <= tc_q + 1'b1;
        end
      end
    end
  end

  // Conv result register tagged with its center row parity and column
  always_ff @(posedge clk) begin
    if (clr) begin
      conv_q         <= '0;
      conv_v_q       <= 1'b0;
      conv_c_q       <= '0;
      conv_row_odd_q <= 1'b0;
    end else begin
      conv_v_q <= conv_fire;
      if (conv_fire) begin
        conv_q         <= conv_d;
        conv_c_q       <= tc_q;
        conv_row_odd_q <= row_odd_q;
      end
    end
  end

  // 2x2 pooling: even rows park column-pair maxima, odd rows emit the final max
  always_ff @(posedge clk) begin
    if (clr) begin
      pair_q     <= '0;
      for (int i = 0; i < IMG_W / 2; i++) pool_q[i] <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      feat_cnt_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (conv_v_q) begin
        if (!conv_c_q[0]) begin
          pair_q <= conv_q;
        end else if (!conv_row_odd_q) begin
          pool_q[conv_c_q[CW-1:1]] <= pair_max;
        end else begin
          out_q      <= smax(pool_q[conv_c_q[CW-1:1]], pair_max);
          valid_q    <= 1'b1;
          feat_cnt_q <= feat_cnt_q + 1'b1;
        end
      end
    end
  end

  assign final_result_out   = out_q;
  assign final_result_valid = valid_q;
  assign final_done_signal  = (state_q == DONE);
endmodule

// File: tb/tb_feature_extractor.sv
// tb/tb_feature_extractor.sv - directed frame vectors for feature_extractor
module tb_feature_extractor;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start_signal = 1'b0;
  logic               pixel_valid_in = 1'b0;
  logic [7:0]         pixel_in = 8'd0;
  logic signed [21:0] final_result_out;
  logic               final_result_valid;
  logic               final_done_signal;

  feature_extractor dut (
    .clk(clk), .rst(rst), .start_signal(start_signal), .pixel_valid_in(pixel_valid_in),
    .pixel_in(pixel_in), .final_result_out(final_result_out),
    .final_result_valid(final_result_valid), .final_done_signal(final_done_signal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [21:0] got [256];
  int  vcnt, dcnt, first_v, last_v, done_c, coinc;
  bit  mon_clr = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      vcnt = 0; dcnt = 0; first_v = -1; last_v = -1; done_c = -1; coinc = 0;
    end else begin
      if (final_result_valid) begin
        if (vcnt < 256) got[vcnt] = final_result_out;
        if (vcnt == 0) first_v = cyc;
        last_v = cyc;
        vcnt++;
      end
      if (final_done_signal) begin
        dcnt++;
        done_c = cyc;
        if (final_result_valid) coinc++;
      end
    end
  end

  typedef struct {
    int pat;     // 0 zero, 1 constant 10, 2 single pixel (2,2)=100
    bit gaps;
    int pre;     // 0 none, 1 reset at pixel 500, 2 restart after 300 pixels
    int v00;
    int v10;
    int col0;    // expected out(m,0) for m >= 2
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic signed [63:0] g, input logic signed [63:0] e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, g, e);
    end
  endtask

  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    if (pat == 1) return 8'd10;
    if (pat == 2 && r == 2 && c == 2) return 8'd100;
    return 8'd0;
  endfunction

  function automatic int expv(input vec_t v, input int m, input int n);
    if (n != 0) return 0;
    if (m == 0) return v.v00;
    if (m == 1) return v.v10;
    return v.col0;
  endfunction

  // start pulse carries a valid garbage pixel that must not be taken
  task automatic start_pulse();
    start_signal = 1'b1; pixel_valid_in = 1'b1; pixel_in = 8'hFF; mon_clr = 1'b1;
    tick();
    start_signal = 1'b0; pixel_valid_in = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic send_pixels(input int pat, input int n, input bit gaps, output int p66, output int plast);
    p66 = -1; plast = -1;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        repeat ($urandom_range(1, 3)) begin
          pixel_valid_in = 1'b0; pixel_in = 8'($urandom);
          tick();
        end
      end
      pixel_valid_in = 1'b1;
      pixel_in = pix(pat, k / 32, k % 32);
      if (k == 66) p66 = cyc;
      plast = cyc;
      tick();
    end
    pixel_valid_in = 1'b1;
    pixel_in = 8'hAA;
  endtask

  vec_t vecs [6];
  int p66, plast, nb, fi;

  initial begin
    vecs[0] = '{pat: 0, gaps: 1'b0, pre: 0, v00: 0,   v10: 0,   col0: 0};
    vecs[1] = '{pat: 1, gaps: 1'b0, pre: 0, v00: 40,  v10: 40,  col0: 40};
    vecs[2] = '{pat: 2, gaps: 1'b0, pre: 0, v00: 100, v10: 200, col0: 0};
    vecs[3] = '{pat: 1, gaps: 1'b1, pre: 0, v00: 40,  v10: 40,  col0: 40};
    vecs[4] = '{pat: 0, gaps: 1'b0, pre: 1, v00: 0,   v10: 0,   col0: 0};
    vecs[5] = '{pat: 2, gaps: 1'b0, pre: 2, v00: 100, v10: 200, col0: 0};

    rst = 1'b0;
    repeat (3) tick();
    chk("reset_out", final_result_out, 0);
    chk("reset_valid", final_result_valid, 0);
    chk("reset_done", final_done_signal, 0);
    rst = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].pre == 1) begin
        start_pulse();
        send_pixels(1, 500, 1'b0, p66, plast);
        rst = 1'b0; mon_clr = 1'b1;
        tick();
        chk($sformatf("v%0d_midrst_out", v), final_result_out, 0);
        chk($sformatf("v%0d_midrst_valid", v), final_result_valid, 0);
        chk($sformatf("v%0d_midrst_done", v), final_done_signal, 0);
        rst = 1'b1; mon_clr = 1'b0;
        repeat (100) tick();
        chk($sformatf("v%0d_quiet_valids", v), vcnt, 0);
        chk($sformatf("v%0d_quiet_dones", v), dcnt, 0);
      end else if (vecs[v].pre == 2) begin
        start_pulse();
        send_pixels(1, 300, 1'b0, p66, plast);
      end

      start_pulse();
      send_pixels(vecs[v].pat, 1024, vecs[v].gaps, p66, plast);
      for (int i = 0; i < 3000 && dcnt == 0; i++) tick();
      repeat (5) tick();
      pixel_valid_in = 1'b0;

      chk($sformatf("v%0d_nvalid", v), vcnt, 256);
      chk($sformatf("v%0d_ndone", v), dcnt, 1);
      chk($sformatf("v%0d_done_coincident", v), coinc, 0);
      chk($sformatf("v%0d_done_after_last", v), done_c - last_v, 1);
      chk($sformatf("v%0d_first_latency", v), first_v - p66, 2);
      chk($sformatf("v%0d_last_latency", v), last_v - plast, 35);

      nb = 0; fi = -1;
      for (int i = 0; i < 256 && i < vcnt; i++) begin
        if (got[i] !== 22'(expv(vecs[v], i / 16, i % 16))) begin
          if (fi < 0) fi = i;
          nb++;
        end
      end
      n_cmp++;
      if (nb != 0) begin
        n_bad++;
        $display("FAIL v%0d_values: %0d wrong, first out(%0d,%0d) got %0d expected %0d",
                 v, nb, fi / 16, fi % 16, got[fi], expv(vecs[v], fi / 16, fi % 16));
      end
      if (vcnt >= 18) begin
        chk($sformatf("v%0d_out00", v), got[0], vecs[v].v00);
        chk($sformatf("v%0d_out10", v), got[16], vecs[v].v10);
        chk($sformatf("v%0d_out01", v), got[1], 0);
        chk($sformatf("v%0d_out11", v), got[17], 0);
      end else begin
        chk($sformatf("v%0d_enough_outputs", v), vcnt, 256);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
